// File: rtl/qpi_pkg.sv
// Shared constants and state encoding for the QPI PSRAM responder.
// Holds the command bytes, address nibble count and the FSM state type.
package qpi_pkg;

    localparam logic [7:0] QPI_CMD_READ_QUAD  = 8'hEB;
    localparam logic [7:0] QPI_CMD_WRITE_QUAD = 8'h38;
    localparam int         QPI_ADDR_NIBBLES   = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qpi_state_e;

endpackage

// File: rtl/qpi_resp_sync.sv
// Two-flop synchronizers for the QPI pins plus spi_clk edge pulses.
// Ports: clk, rst_n, i_spi_clk, i_spi_ncs, i_spi_sin -> o_ncs, o_sin, o_rise, o_fall.
module qpi_resp_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_spi_clk,
    input  logic       i_spi_ncs,
    input  logic [3:0] i_spi_sin,
    output logic       o_ncs,
    output logic [3:0] o_sin,
    output logic       o_rise,
    output logic       o_fall
);

    logic [2:0] r_clk;
    logic [1:0] r_ncs;
    logic [3:0] r_sin1;
    logic [3:0] r_sin2;

    // ncs resets to the deasserted level so reset never looks like a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk  <= 3'b000;
            r_ncs  <= 2'b11;
            r_sin1 <= 4'h0;
            r_sin2 <= 4'h0;
        end else begin
            r_clk  <= {r_clk[1:0], i_spi_clk};
            r_ncs  <= {r_ncs[0], i_spi_ncs};
            r_sin1 <= i_spi_sin;
            r_sin2 <= r_sin1;
        end
    end

    // sin shares the clock's sync depth, so at a rise pulse it shows
    // the value present just after the pin edge
    assign o_rise = r_clk[1] & ~r_clk[2];
    assign o_fall = ~r_clk[1] & r_clk[2];
    assign o_ncs  = r_ncs[1];
    assign o_sin  = r_sin2;

endmodule

// File: rtl/qpi_psram_responder.sv
// QPI slave modelling one LY68L6400-style PSRAM over an external byte memory.
// Ports: clk, rst_n, spi_clk/ncs/sin/sout/oe, mem_addr/wdata/we/re/rdata,
// busy, err_cmd. Optional macro QPI_RESP_PAGE_WRAP_EN: burst address wraps
// inside a 1024-byte page; otherwise it increments across ADDR_BITS.
module qpi_psram_responder
    import qpi_pkg::*;
#(
    parameter logic [7:0] READCMD   = QPI_CMD_READ_QUAD,
    parameter logic [7:0] WRITECMD  = QPI_CMD_WRITE_QUAD,
    parameter int         READDUMMY = 6,
    parameter int         ADDR_BITS = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_clk,
    input  logic                 spi_ncs,
    input  logic [3:0]           spi_sin,
    output logic [3:0]           spi_sout,
    output logic                 spi_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 err_cmd
);

    localparam logic [4:0] LAST_ADDR = 5'(QPI_ADDR_NIBBLES - 1);

    logic                 w_ncs;
    logic [3:0]           w_sin;
    logic                 w_rise;
    logic                 w_fall;
    logic [7:0]           w_cmd;
    logic [ADDR_BITS-1:0] w_addr_in;
    logic [ADDR_BITS-1:0] w_addr_inc;

    qpi_state_e           r_state;
    logic [4:0]           r_cnt;
    logic [3:0]           r_hi;
    logic [19:0]          r_ashift;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_read;
    logic                 r_lo;
    logic                 r_fetch;
    logic [7:0]           r_shift;

    qpi_resp_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_spi_clk (spi_clk),
        .i_spi_ncs (spi_ncs),
        .i_spi_sin (spi_sin),
        .o_ncs     (w_ncs),
        .o_sin     (w_sin),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_cmd     = {r_hi, w_sin};
    assign w_addr_in = ADDR_BITS'({r_ashift, w_sin});

`ifdef QPI_RESP_PAGE_WRAP_EN
    assign w_addr_inc = {r_addr[ADDR_BITS-1:10], r_addr[9:0] + 10'd1};
`else
    assign w_addr_inc = r_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_hi      <= 4'h0;
            r_ashift  <= 20'h0;
            r_addr    <= '0;
            r_read    <= 1'b0;
            r_lo      <= 1'b0;
            r_fetch   <= 1'b0;
            r_shift   <= 8'h00;
            spi_sout  <= 4'h0;
            spi_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            err_cmd   <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            err_cmd <= 1'b0;
            busy    <= ~w_ncs & (r_state != ST_IDLE);
            // rdata is valid the cycle after the strobe
            r_fetch <= mem_re;
            if (r_fetch) begin
                r_shift <= mem_rdata;
            end
            // deselect beats any edge seen in the same cycle
            if (w_ncs) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 5'd0;
                r_lo     <= 1'b0;
                spi_oe   <= 1'b0;
                spi_sout <= 4'h0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_CMD;
                        r_cnt   <= 5'd0;
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            if (r_cnt == 5'd0) begin
                                r_hi  <= w_sin;
                                r_cnt <= 5'd1;
                            end else begin
                                r_cnt <= 5'd0;
                                if (w_cmd == READCMD || w_cmd == WRITECMD) begin
                                    r_read  <= (w_cmd == READCMD);
                                    r_state <= ST_ADDR;
                                end else begin
                                    err_cmd <= 1'b1;
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_ashift <= {r_ashift[15:0], w_sin};
                            if (r_cnt == LAST_ADDR) begin
                                r_addr <= w_addr_in;
                                r_cnt  <= 5'd0;
                                if (r_read) begin
                                    mem_addr <= w_addr_in;
                                    mem_re   <= 1'b1;
                                    r_cnt    <= 5'(READDUMMY);
                                    r_state  <= ST_DUMMY;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (w_rise && r_cnt != 5'd0) begin
                            r_cnt <= r_cnt - 5'd1;
                        end else if (w_fall && r_cnt == 5'd0) begin
                            spi_oe   <= 1'b1;
                            spi_sout <= r_shift[7:4];
                            r_lo     <= 1'b1;
                            r_state  <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (w_fall) begin
                            if (r_lo) begin
                                // low nibble out: prefetch the next byte
                                spi_sout <= r_shift[3:0];
                                r_lo     <= 1'b0;
                                r_addr   <= w_addr_inc;
                                mem_addr <= w_addr_inc;
                                mem_re   <= 1'b1;
                            end else begin
                                spi_sout <= r_shift[7:4];
                                r_lo     <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_rise) begin
                            if (!r_lo) begin
                                r_hi <= w_sin;
                                r_lo <= 1'b1;
                            end else begin
                                r_lo      <= 1'b0;
                                mem_we    <= 1'b1;
                                mem_wdata <= {r_hi, w_sin};
                                mem_addr  <= r_addr;
                                r_addr    <= w_addr_inc;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_state <= ST_IGNORE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpi_psram_responder.sv
// Scoreboard bench for qpi_psram_responder: two lanes, directed QPI traffic.
// Expected write strobes and read nibbles are queued and checked by monitors.
module tb_qpi_psram_responder;

    logic        clk;
    logic        rst_n;
    logic        spi_clk;
    logic        ncs_a;
    logic        ncs_b;
    logic [3:0]  sin_a;
    logic [3:0]  sin_b;
    logic [3:0]  sout_a;
    logic [3:0]  sout_b;
    logic        oe_a;
    logic        oe_b;
    logic [22:0] addr_a;
    logic [22:0] addr_b;
    logic [7:0]  wdata_a;
    logic [7:0]  wdata_b;
    logic        we_a;
    logic        we_b;
    logic        re_a;
    logic        re_b;
    logic [7:0]  rdata_a;
    logic [7:0]  rdata_b;
    logic        busy_a;
    logic        busy_b;
    logic        err_a;
    logic        err_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_a = 0;
    int n_err_b = 0;
    int n_re_a = 0;
    logic rd_phase = 1'b0;

    logic [30:0] q_wa[$];
    logic [30:0] q_wb[$];
    logic [3:0]  q_rd[$];
    logic [7:0]  mem_a[int];

    qpi_psram_responder dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_ncs   (ncs_a),
        .spi_sin   (sin_a),
        .spi_sout  (sout_a),
        .spi_oe    (oe_a),
        .mem_addr  (addr_a),
        .mem_wdata (wdata_a),
        .mem_we    (we_a),
        .mem_re    (re_a),
        .mem_rdata (rdata_a),
        .busy      (busy_a),
        .err_cmd   (err_a)
    );

    qpi_psram_responder dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_ncs   (ncs_b),
        .spi_sin   (sin_b),
        .spi_sout  (sout_b),
        .spi_oe    (oe_b),
        .mem_addr  (addr_b),
        .mem_wdata (wdata_b),
        .mem_we    (we_b),
        .mem_re    (re_b),
        .mem_rdata (rdata_b),
        .busy      (busy_b),
        .err_cmd   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata_b = 8'h00;

    always @(posedge clk) begin
        if (we_a) mem_a[int'(addr_a)] = wdata_a;
        if (re_a) rdata_a <= mem_a.exists(int'(addr_a)) ? mem_a[int'(addr_a)] : 8'h00;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // write-strobe monitor
    always @(negedge clk) begin
        if (err_a) n_err_a++;
        if (err_b) n_err_b++;
        if (re_a) n_re_a++;
        if (we_a) begin
            if (q_wa.size() == 0) check("wr_a_unexpected", {1'b0, addr_a, wdata_a}, 32'hFFFFFFFF);
            else check("wr_a", {1'b0, addr_a, wdata_a}, {1'b0, q_wa.pop_front()});
        end
        if (we_b) begin
            if (q_wb.size() == 0) check("wr_b_unexpected", {1'b0, addr_b, wdata_b}, 32'hFFFFFFFF);
            else check("wr_b", {1'b0, addr_b, wdata_b}, {1'b0, q_wb.pop_front()});
        end
    end

    // read-nibble monitor: master samples sout on its rising edge
    always @(posedge spi_clk) begin
        if (rd_phase) begin
            if (q_rd.size() == 0) check("rd_unexpected", {28'h0, sout_a}, 32'hFFFFFFFF);
            else check("rd_nib", {28'h0, sout_a}, {28'h0, q_rd.pop_front()});
        end
    end

    task automatic nib2(input logic [3:0] a, input logic [3:0] b);
        sin_a = a;
        sin_b = b;
        #60 spi_clk = 1'b1;
        #60 spi_clk = 1'b0;
    endtask

    task automatic nib(input logic [3:0] a);
        nib2(a, 4'h0);
    endtask

    task automatic byte_a(input logic [7:0] v);
        nib(v[7:4]);
        nib(v[3:0]);
    endtask

    task automatic addr_out(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) nib(a[4*i +: 4]);
    endtask

    task automatic sel_a();
        ncs_a = 1'b0;
        #100;
    endtask

    task automatic desel();
        #60;
        ncs_a = 1'b1;
        ncs_b = 1'b1;
        #200;
    endtask

    task automatic push_wa(input logic [22:0] a, input logic [7:0] d);
        q_wa.push_back({a, d});
    endtask

    logic [31:0] word;
    int          base_err;
    int          base_re;
    logic [22:0] exp_w1;
    logic [22:0] exp_w2;

    initial begin
        rst_n   = 1'b0;
        spi_clk = 1'b0;
        ncs_a   = 1'b1;
        ncs_b   = 1'b1;
        sin_a   = 4'h0;
        sin_b   = 4'h0;
        #100;
        check("rst_oe", {31'h0, oe_a}, 32'h0);
        check("rst_we_re", {30'h0, we_a, re_a}, 32'h0);
        check("rst_busy_err", {30'h0, busy_a, err_a}, 32'h0);
        check("rst_addr", {9'h0, addr_a}, 32'h0);
        check("rst_sout", {28'h0, sout_a}, 32'h0);
        rst_n = 1'b1;
        #100;

        // plain write burst
        push_wa(23'h000010, 8'hA5);
        push_wa(23'h000011, 8'h3C);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h000010);
        byte_a(8'hA5);
        byte_a(8'h3C);
        desel();
        check("wr_burst_left", q_wa.size(), 32'd0);

        // quad read with dummies
        mem_a[32'h20] = 8'hDE;
        mem_a[32'h21] = 8'hAD;
        sel_a();
        byte_a(8'hEB);
        addr_out(24'h000020);
        for (int i = 0; i < 6; i++) nib(4'h0);
        check("oe_before_fall", {31'h0, oe_a}, 32'h0);
        #40;
        check("oe_after_fall", {31'h0, oe_a}, 32'h1);
        q_rd.push_back(4'hD);
        q_rd.push_back(4'hE);
        q_rd.push_back(4'hA);
        q_rd.push_back(4'hD);
        rd_phase = 1'b1;
        for (int i = 0; i < 4; i++) nib(4'h0);
        rd_phase = 1'b0;
        desel();
        check("oe_after_ncs", {31'h0, oe_a}, 32'h0);

        // unknown command
        base_err = n_err_a;
        base_re  = n_re_a;
        sel_a();
        byte_a(8'h9F);
        for (int i = 0; i < 6; i++) nib(4'h5);
        check("ign_oe", {31'h0, oe_a}, 32'h0);
        check("ign_busy", {31'h0, busy_a}, 32'h1);
        desel();
        check("err_pulses", n_err_a - base_err, 32'd1);
        check("ign_no_re", n_re_a - base_re, 32'd0);
        push_wa(23'h000000, 8'h55);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h000000);
        byte_a(8'h55);
        desel();

        // address wrap at the top of the array and at a page edge
`ifdef QPI_RESP_PAGE_WRAP_EN
        exp_w1 = 23'h7FFC00;
        exp_w2 = 23'h000000;
`else
        exp_w1 = 23'h000000;
        exp_w2 = 23'h000400;
`endif
        push_wa(23'h7FFFFF, 8'h12);
        push_wa(exp_w1, 8'h34);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h7FFFFF);
        byte_a(8'h12);
        byte_a(8'h34);
        desel();
        push_wa(23'h0003FF, 8'h56);
        push_wa(exp_w2, 8'h78);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h0003FF);
        byte_a(8'h56);
        byte_a(8'h78);
        desel();
        check("wrap_left", q_wa.size(), 32'd0);

        // upper address bits beyond ADDR_BITS are dropped
        push_wa(23'h000042, 8'h9A);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h800042);
        byte_a(8'h9A);
        desel();

        // deselect after one data nibble discards the byte
        sel_a();
        byte_a(8'h38);
        addr_out(24'h000040);
        nib(4'h7);
        desel();
        check("abort_oe", {31'h0, oe_a}, 32'h0);
        check("abort_busy", {31'h0, busy_a}, 32'h0);
        check("abort_no_we", q_wa.size(), 32'd0);

        // reset in the middle of a read
        sel_a();
        byte_a(8'hEB);
        addr_out(24'h000020);
        for (int i = 0; i < 3; i++) nib(4'h0);
        rst_n = 1'b0;
        #30;
        check("rst_mid_oe", {31'h0, oe_a}, 32'h0);
        check("rst_mid_busy", {31'h0, busy_a}, 32'h0);
        check("rst_mid_we", {31'h0, we_a}, 32'h0);
        ncs_a = 1'b1;
        #100;
        rst_n = 1'b1;
        #100;
        push_wa(23'h000050, 8'h66);
        sel_a();
        byte_a(8'h38);
        addr_out(24'h000050);
        byte_a(8'h66);
        desel();

        // interleaved pair: each clock carries one byte of the 8-bit bus,
        // lane A takes its high nibble and lane B its low nibble
        word = 32'h11223344;
        q_wa.push_back({23'h000002, 8'h13});
        q_wa.push_back({23'h000003, 8'h24});
        q_wb.push_back({23'h000002, 8'h13});
        q_wb.push_back({23'h000003, 8'h24});
        ncs_a = 1'b0;
        ncs_b = 1'b0;
        #100;
        nib2(4'h3, 4'h3);
        nib2(4'h8, 4'h8);
        for (int i = 0; i < 5; i++) nib2(4'h0, 4'h0);
        nib2(4'h2, 4'h2);
        nib2(word[31:28], word[27:24]);
        nib2(word[15:12], word[11:8]);
        nib2(word[23:20], word[19:16]);
        nib2(word[7:4], word[3:0]);
        desel();

        check("left_a", q_wa.size(), 32'd0);
        check("left_b", q_wb.size(), 32'd0);
        check("left_rd", q_rd.size(), 32'd0);
        check("err_b", n_err_b, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qpi_psram_responder.md
Name: qpi_psram_responder

Overview:
- QPI slave that models one LY68L6400-style PSRAM chip in RTL. It receives command, address and dummy nibbles and returns or stores data bytes.
- Byte storage lives in an external synchronous byte memory through a simple port, so the block can stand behind the QPI memory master in simulation and in FPGA loopback tests.
- All QPI pins are oversampled in the single system clock domain.
- Two instances, one per lane, emulate the dual interleaved PSRAM pair.

Parameters:
- READCMD, 8'hEB, quad read command.
- WRITECMD, 8'h38, quad write command.
- READDUMMY, 6, dummy clocks between the last address nibble and the first read nibble.
- ADDR_BITS, 23, implemented byte-address width. Upper address bits are ignored.

Ports:
- clk  in  1  system clock; must run at least 6x spi_clk.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  QPI clock from master.
- spi_ncs  in  1  chip select, active low.
- spi_sin  in  4  nibble from master (master sout).
- spi_sout  out  4  nibble to master (master sin).
- spi_oe  out  1  responder drives spi_sout.
- mem_addr  out  ADDR_BITS  byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe; mem_rdata is valid the next clk.
- mem_rdata  in  8  read byte.
- busy  out  1  high while spi_ncs is low and the block is not IDLE.
- err_cmd  out  1  one-cycle pulse on an unknown command byte.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal address 0.
- Input conditioning: spi_clk, spi_ncs and spi_sin pass through 2-flop synchronizers. Edge detect yields clk-domain pulses spi_rise and spi_fall, 3 clk after the pin edge.
- Sampling and driving: spi_sin is sampled on spi_rise. spi_sout is updated on spi_fall.
- Nibble order: command, address and data are MSB nibble first. A byte is two nibbles, high nibble first.
- spi_ncs high (synchronized), in any state: next cycle state=IDLE, spi_oe=0, nibble counter cleared. A partially received write byte is discarded. No memory strobe is issued after deassert.
- State IDLE: a low spi_ncs moves to CMD with nibble count 0.
- State CMD: takes 2 nibbles.
  - READCMD or WRITECMD goes to ADDR.
  - Any other value pulses err_cmd and goes to IGNORE.
- State IGNORE: stays until spi_ncs is high.
- State ADDR: takes 6 nibbles into a 24-bit register, then mem_addr = addr[ADDR_BITS-1:0].
  - Read: issue mem_re on the cycle after the 6th nibble, latch the byte into the shift register, go to DUMMY with count READDUMMY.
  - Write: go to WDATA.
- State DUMMY: counts READDUMMY spi_rise pulses.
  - On the spi_fall after the final dummy rise: spi_oe=1, spi_sout = high nibble, go to RDATA.
- State RDATA:
  - Each spi_fall alternates high and low nibble.
  - When the low nibble is driven: increment the address, issue mem_re for the next byte, latch it before the next spi_fall.
  - spi_oe stays 1 until ncs rises.
- State WDATA:
  - Each pair of spi_rise pulses assembles a byte.
  - On the second nibble: mem_we=1 with mem_wdata and mem_addr for one clk, then increment the address.
- Address wrap: the increment is modulo 2^ADDR_BITS. All-ones wraps to 0.
- Simultaneous events: if spi_ncs high coincides with spi_rise, the ncs abort wins.
- Reset mid-transfer: immediate return to IDLE. Any mem_we being asserted is dropped.

Optional Feature:
- Macro: QPI_RESP_PAGE_WRAP_EN.
- Defined: burst address increment wraps within a 1024-byte page. Bits [9:0] increment; upper bits are held, matching the LY68L6400 linear burst boundary.
- Undefined: linear increment across the full ADDR_BITS space.

Decomposition:
- Shared package qpi_pkg:
  - command constants QPI_CMD_READ_QUAD=8'hEB and QPI_CMD_WRITE_QUAD=8'h38.
  - state encoding constants for IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - QPI_ADDR_NIBBLES=6.
- One natural sub-module, qpi_resp_sync: synchronizers for spi_clk, spi_ncs and spi_sin, plus the spi_rise/spi_fall pulse generation.

Test Plan:
- Write 38 000010 then bytes A5 3C, ncs high -> mem_we at addr 0x10 = A5 and at 0x11 = 3C; exactly 2 strobes.
- Preload 0x20=DE, 0x21=AD. Send EB 000020, 6 dummies, clock 4 nibbles -> sin sees D,E,A,D. spi_oe rises on the fall after the 6th dummy.
- Command 0x9F -> err_cmd pulses once, no mem strobes, spi_oe stays 0 until ncs high. A following write 38 000000 55 works.
- Write burst at 0x7FFFFF, 2 bytes, macro undefined -> writes at 0x7FFFFF and 0x000000. Macro defined, start 0x0003FF -> second write at 0x000000 (page wrap, upper bits held).
- ncs high after 1 data nibble of a write, and rst_n low mid-read -> no mem_we, spi_oe=0, state IDLE. The next transaction decodes correctly.
- Interleaved pair: two instances, master sends 32-bit word 0x11223344 at word addr 4 -> lane A byte addr 2 = 0x13, 3 = 0x24; lane B byte addr 2 = 0x13, 3 = 0x24 per the nibble split.
